sigma_cpu: RTL and testbench

SIGMA_CPU -- requirements
Module: sigma_cpu

---
 rtl/sigma_pkg.sv | 48 ++++
 rtl/sigma_regfile.sv | 42 ++++
 rtl/sigma_cpu.sv | 166 ++++++++++++++++
 tb/tb_sigma_cpu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sigma_pkg.sv
// Shared definitions for the Sigma-style CPU: field positions, opcodes,
// FSM state encoding and small decode helpers.
// Fields are numbered big-endian (bit 0 = MSB); the *_LSB constants give
// the little-endian index of each field inside a [31:0] word.
package sigma_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned REG_N  = 16;
  localparam int unsigned RIDX_W = 4;
  localparam int unsigned XIDX_W = 3;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned CC_W   = 4;
  localparam int unsigned IMM_W  = 20;

  // Sigma bit n maps to little-endian bit (31 - n)
  localparam int unsigned IND_BIT  = 31;  // bit 0
  localparam int unsigned OP_LSB   = 24;  // bits 1-7
  localparam int unsigned R_LSB    = 20;  // bits 8-11
  localparam int unsigned X_LSB    = 17;  // bits 12-14
  localparam int unsigned ADDR_LSB = 0;   // bits 15-31
  localparam int unsigned IMM_LSB  = 0;   // bits 12-31

  localparam logic [OP_W-1:0] OP_AI   = 7'h20;
  localparam logic [OP_W-1:0] OP_LI   = 7'h22;
  localparam logic [OP_W-1:0] OP_WAIT = 7'h2E;
  localparam logic [OP_W-1:0] OP_AW   = 7'h30;
  localparam logic [OP_W-1:0] OP_LW   = 7'h32;
  localparam logic [OP_W-1:0] OP_BCR  = 7'h68;
  localparam logic [OP_W-1:0] OP_BCS  = 7'h69;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } cpu_state_e;

  // Sign-extend the 20-bit immediate held in bits 12-31
  function automatic logic [WORD_W-1:0] sext_imm(input logic [WORD_W-1:0] ir);
    return {{(WORD_W - IMM_W){ir[IMM_LSB + IMM_W - 1]}}, ir[IMM_LSB +: IMM_W]};
  endfunction

  // {CC3, CC4}: positive / negative indication of a result
  function automatic logic [1:0] cc_sign(input logic [WORD_W-1:0] v);
    return {(v != '0) && !v[WORD_W-1], v[WORD_W-1]};
  endfunction

endpackage

// File: rtl/sigma_regfile.sv
// 16 x 32-bit general register file.
// Ports: clock, reset (sync, active-high, clears all registers),
//   raddr_r/rdata_r and raddr_x/rdata_x: combinational read ports,
//   we/waddr/wdata: synchronous write port.
module sigma_regfile
  import sigma_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [RIDX_W-1:0] raddr_r,
  output logic [WORD_W-1:0] rdata_r,
  input  logic [RIDX_W-1:0] raddr_x,
  output logic [WORD_W-1:0] rdata_x,
  input  logic              we,
  input  logic [RIDX_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata
);

  logic [WORD_W-1:0] regs_q [REG_N];
  logic [WORD_W-1:0] regs_d [REG_N];

  assign rdata_r = regs_q[raddr_r];
  assign rdata_x = regs_q[raddr_x];

  // Next register contents
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register storage; reset wins over a pending write
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/sigma_cpu.sv
// Minimal Sigma-style CPU: two-cycle FETCH/EXEC machine with LI, AI, LW,
// AW, BCR, BCS and WAIT; all other opcodes are no-ops.
// Ports: clock, reset (sync, active-high),
//   memory_data_in [0:31]: memory word, combinational response to address,
//   memory_address [0:16]: word address (read-only memory port).
module sigma_cpu
  import sigma_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 17'h00000
) (
  input  logic        reset,
  input  logic        clock,
  input  logic [0:31] memory_data_in,
  output logic [0:16] memory_address
);

  cpu_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [CC_W-1:0]   cc_q, cc_d;

  logic [WORD_W-1:0] mem_word;
  logic [OP_W-1:0]   opcode;
  logic [RIDX_W-1:0] r_idx;
  logic [XIDX_W-1:0] x_idx;
  logic [ADDR_W-1:0] ref_addr;
  logic [ADDR_W-1:0] ea;
  logic [WORD_W-1:0] imm;
  logic [WORD_W-1:0] rd_r, rd_x;
  logic [WORD_W-1:0] add_operand;
  logic [WORD_W:0]   sum;
  logic              ovf;
  logic              rf_we;
  logic [WORD_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] mem_addr_c;
  logic              unused_bits;

  // Big-endian [0:31] maps position-for-position onto [31:0]
  assign mem_word = memory_data_in;

  assign opcode   = ir_q[OP_LSB +: OP_W];
  assign r_idx    = ir_q[R_LSB +: RIDX_W];
  assign x_idx    = ir_q[X_LSB +: XIDX_W];
  assign ref_addr = ir_q[ADDR_LSB +: ADDR_W];
  assign imm      = sext_imm(ir_q);

  // Indirect flag and upper index bits take no part in execution
  assign unused_bits = ^{ir_q[IND_BIT], rd_x[WORD_W-1:ADDR_W]};

  sigma_regfile u_rf (
    .clock   (clock),
    .reset   (reset),
    .raddr_r (r_idx),
    .rdata_r (rd_r),
    .raddr_x (RIDX_W'(x_idx)),
    .rdata_x (rd_x),
    .we      (rf_we),
    .waddr   (r_idx),
    .wdata   (rf_wdata)
  );

  // Effective address: X=0 means no indexing; wraps mod 2^17
  assign ea = ref_addr + ((x_idx != '0) ? rd_x[ADDR_W-1:0] : '0);

  // Shared adder for AI/AW, with carry out of bit 0 and signed overflow
  always_comb begin
    add_operand = (opcode == OP_AW) ? mem_word : imm;
    sum = {1'b0, rd_r} + {1'b0, add_operand};
    ovf = (rd_r[WORD_W-1] == add_operand[WORD_W-1]) &&
          (sum[WORD_W-1] != rd_r[WORD_W-1]);
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = (opcode == OP_WAIT) ? ST_HALT : ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // FSM output: memory address (reset overrides any in-flight EA)
  always_comb begin
    mem_addr_c = pc_q;
    if (reset) begin
      mem_addr_c = RESET_PC;
    end else if (state_q == ST_EXEC) begin
      mem_addr_c = ea;
    end
  end

  assign memory_address = mem_addr_c;

  // Datapath: fetch latch and instruction execution
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    cc_d     = cc_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    if (state_q == ST_FETCH) begin
      ir_d = mem_word;
      pc_d = pc_q + ADDR_W'(1);
    end else if (state_q == ST_EXEC) begin
      case (opcode)
        OP_LI: begin
          rf_we    = 1'b1;
          rf_wdata = imm;
          cc_d     = {cc_q[3:2], cc_sign(imm)};
        end
        OP_LW: begin
          rf_we    = 1'b1;
          rf_wdata = mem_word;
          cc_d     = {cc_q[3:2], cc_sign(mem_word)};
        end
        OP_AI, OP_AW: begin
          rf_we    = 1'b1;
          rf_wdata = sum[WORD_W-1:0];
          cc_d     = {sum[WORD_W], ovf, cc_sign(sum[WORD_W-1:0])};
        end
        OP_BCR: begin
          if ((cc_q & r_idx) == '0) pc_d = ea;
        end
        OP_BCS: begin
          if ((cc_q & r_idx) != '0) pc_d = ea;
        end
        default: begin
        end
      endcase
    end
  end

  // Architectural state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
      cc_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      cc_q <= cc_d;
    end
  end

`ifndef SYNTHESIS
  // Instruction trace on every fetch
  always_ff @(posedge clock) begin
    if (!reset && state_q == ST_FETCH) begin
      $write("sigma fetch pc=%05h ir=%08h\n", pc_q, mem_word);
    end
  end
`endif

endmodule

// File: tb/tb_sigma_cpu.sv
// Directed bench for sigma_cpu: small programs in a behavioural memory,
// outputs sampled on the falling clock edge.
module tb_sigma_cpu;

  logic        clock;
  logic        reset;
  logic [31:0] mem_rd;
  logic [16:0] mem_addr;
  logic [31:0] mem [256];

  int total = 0;
  int bad   = 0;

  sigma_cpu #(.RESET_PC(17'h00000)) dut (
    .reset          (reset),
    .clock          (clock),
    .memory_data_in (mem_rd),
    .memory_address (mem_addr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Combinational memory; addresses beyond the array read as a no-op word
  always_comb begin
    mem_rd = 32'h0;
    if (mem_addr < 17'd256) begin
      mem_rd = mem[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    clear_mem();

    // Program A: LI / AI / LI negative / WAIT at 3
    mem[0] = 32'h22100005;  // LI R1,5
    mem[1] = 32'h20100003;  // AI R1,3
    mem[2] = 32'h221FFFFF;  // LI R1,-1
    mem[3] = 32'h2E000000;  // WAIT
    cycles(2);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_r1", dut.u_rf.regs_q[1], 32'h0);
    check("rst_cc", 32'(dut.cc_q), 32'h0);
    reset = 1'b0;
    #1 check("a_fetch0_addr", 32'(mem_addr), 32'h0);
    cycles(1);
    check("a_li_ea", 32'(mem_addr), 32'h5);
    cycles(1);
    check("a_li_r1", dut.u_rf.regs_q[1], 32'h00000005);
    check("a_li_cc", 32'(dut.cc_q), 32'h2);
    check("a_fetch1_addr", 32'(mem_addr), 32'h1);
    cycles(2);
    check("a_ai_r1", dut.u_rf.regs_q[1], 32'h00000008);
    check("a_ai_cc", 32'(dut.cc_q), 32'h2);
    cycles(2);
    check("a_lineg_r1", dut.u_rf.regs_q[1], 32'hFFFFFFFF);
    check("a_lineg_cc", 32'(dut.cc_q), 32'h1);
    cycles(2);
    check("a_halt_addr", 32'(mem_addr), 32'h4);
    cycles(10);
    check("a_halt_hold", 32'(mem_addr), 32'h4);

    // Program B: loads, adds, carry, overflow, indexed AW
    reset = 1'b1;
    cycles(1);
    clear_mem();
    mem[0]    = 32'h32200040;  // LW R2,0x40
    mem[1]    = 32'h30200040;  // AW R2,0x40
    mem[2]    = 32'h223FFFFF;  // LI R3,-1
    mem[3]    = 32'h20300001;  // AI R3,1 -> 0 with carry
    mem[4]    = 32'h32500041;  // LW R5,0x41
    mem[5]    = 32'h30500041;  // AW R5,0x41 -> overflow
    mem[6]    = 32'h22100040;  // LI R1,0x40
    mem[7]    = 32'h30120000;  // AW R1,0,X=1
    mem[8]    = 32'h2E000000;  // WAIT
    mem[8'h40] = 32'h12345678;
    mem[8'h41] = 32'h7FFFFFFF;
    cycles(1);
    reset = 1'b0;
    cycles(1);
    check("b_lw_ea", 32'(mem_addr), 32'h40);
    cycles(1);
    check("b_lw_r2", dut.u_rf.regs_q[2], 32'h12345678);
    check("b_lw_cc", 32'(dut.cc_q), 32'h2);
    cycles(2);
    check("b_aw_r2", dut.u_rf.regs_q[2], 32'h2468ACF0);
    check("b_aw_cc", 32'(dut.cc_q), 32'h2);
    cycles(2);
    check("b_li_r3", dut.u_rf.regs_q[3], 32'hFFFFFFFF);
    check("b_li_cc", 32'(dut.cc_q), 32'h1);
    cycles(2);
    check("b_carry_r3", dut.u_rf.regs_q[3], 32'h0);
    check("b_carry_cc", 32'(dut.cc_q), 32'h8);
    cycles(2);
    check("b_lw_r5", dut.u_rf.regs_q[5], 32'h7FFFFFFF);
    check("b_lw_keep_cc", 32'(dut.cc_q), 32'hA);
    cycles(2);
    check("b_ovf_r5", dut.u_rf.regs_q[5], 32'hFFFFFFFE);
    check("b_ovf_cc", 32'(dut.cc_q), 32'h5);
    cycles(2);
    check("b_li_r1", dut.u_rf.regs_q[1], 32'h00000040);
    check("b_li_keep_cc", 32'(dut.cc_q), 32'h6);
    cycles(1);
    check("b_idx_ea", 32'(mem_addr), 32'h40);
    cycles(1);
    check("b_idx_r1", dut.u_rf.regs_q[1], 32'h123456B8);
    check("b_idx_cc", 32'(dut.cc_q), 32'h2);
    cycles(2);
    check("b_halt_addr", 32'(mem_addr), 32'h9);

    // Program C: branches, no-op, then reset mid-instruction
    reset = 1'b1;
    cycles(1);
    clear_mem();
    mem[0]     = 32'h68000010;  // BCR 0,0x10 (always taken)
    mem[8'h10] = 32'h22100001;  // LI R1,1
    mem[8'h11] = 32'h69200020;  // BCS 2,0x20 (taken)
    mem[8'h20] = 32'h69800030;  // BCS 8,0x30 (not taken)
    mem[8'h21] = 32'h68200030;  // BCR 2,0x30 (not taken)
    mem[8'h22] = 32'h01100000;  // undefined opcode: no-op
    mem[8'h23] = 32'h22100007;  // LI R1,7 (aborted by reset)
    cycles(1);
    reset = 1'b0;
    cycles(2);
    check("c_bcr_addr", 32'(mem_addr), 32'h10);
    cycles(2);
    check("c_li_r1", dut.u_rf.regs_q[1], 32'h1);
    cycles(2);
    check("c_bcs_taken", 32'(mem_addr), 32'h20);
    cycles(2);
    check("c_bcs_not", 32'(mem_addr), 32'h21);
    cycles(2);
    check("c_bcr_not", 32'(mem_addr), 32'h22);
    cycles(2);
    check("c_nop_addr", 32'(mem_addr), 32'h23);
    check("c_nop_r1", dut.u_rf.regs_q[1], 32'h1);
    check("c_nop_cc", 32'(dut.cc_q), 32'h2);
    cycles(1);
    reset = 1'b1;
    #1 check("c_rst_addr_now", 32'(mem_addr), 32'h0);
    cycles(1);
    check("c_abort_r1", dut.u_rf.regs_q[1], 32'h0);
    check("c_abort_cc", 32'(dut.cc_q), 32'h0);
    reset = 1'b0;
    #1 check("c_restart_addr", 32'(mem_addr), 32'h0);
    cycles(2);
    check("c_restart_branch", 32'(mem_addr), 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
